mac_operand_feeder: RTL and testbench

Operand sequencer that drives the signed multiply-accumulate unit for one output value per start. It reads a conv window (5x5) or a fully-connected row (192 taps) from the feature and weight RAMs, streams operand pairs to the accumulator's `enable`/`A`/`B` inputs, and enforces the accumulator's capture gap. It pulses `done` in the one cycle where the accumulator's 32-bit `out` is valid.

---
 rtl/mac_operand_feeder.sv | 215 +++++++++++++++++++++
 tb/tb_mac_operand_feeder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: fetches one conv 5x5 window (25 taps) or one FC row
// (192 taps) from the feature and weight RAMs. It streams the operand pairs
// into the signed MAC, inserts the accumulator's capture gap, and pulses done
// in the cycle the MAC result is valid.
module mac_operand_feeder #(
    parameter int FADDR_W = 10,
    parameter int WADDR_W = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         layer,
    input  logic [FADDR_W-1:0] f_base,
    input  logic [FADDR_W-1:0] row_stride,
    input  logic [WADDR_W-1:0] w_base,
    output logic               f_rd,
    output logic [FADDR_W-1:0] f_addr,
    input  logic [15:0]        f_data,
    output logic               w_rd,
    output logic [WADDR_W-1:0] w_addr,
    input  logic [15:0]        w_data,
    output logic               mac_enable,
    output logic signed [15:0] mac_a,
    output logic signed [15:0] mac_b,
    output logic [2:0]         mac_layer,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int CONV_TAPS = 25;
    localparam int FC_TAPS   = 192;
    localparam int CONV_COLS = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    // Tap bookkeeping for the current run.
    logic [7:0]         tap_q, tap_d;
    logic [7:0]         last_tap_q, last_tap_d;
    logic [2:0]         col_q, col_d;
    logic               is_conv_q, is_conv_d;
    logic [FADDR_W-1:0] row_ptr_q, row_ptr_d;
    logic [FADDR_W-1:0] stride_q, stride_d;

    // RAM read side. One read strobe serves both RAMs.
    logic               rd_q, rd_d;
    logic [FADDR_W-1:0] f_addr_q, f_addr_d;
    logic [WADDR_W-1:0] w_addr_q, w_addr_d;

    // Operand pipe: rd_valid marks the cycle in which RAM data is present.
    logic               rd_valid_q, rd_valid_d;
    logic               mac_enable_q, mac_enable_d;
    logic signed [15:0] mac_a_q, mac_a_d;
    logic signed [15:0] mac_b_q, mac_b_d;
    logic [2:0]         layer_q, layer_d;

    // Status pulses and levels.
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               layer_legal;
    logic               last_tap;
    logic               col_wrap;
    logic [FADDR_W-1:0] next_row_ptr;

    assign layer_legal  = (layer <= 3'd2);
    assign last_tap     = (tap_q == last_tap_q);
    assign col_wrap     = is_conv_q && (col_q == 3'(CONV_COLS - 1));
    assign next_row_ptr = row_ptr_q + stride_q;

    // Next-state, address generation and operand pipe.
    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        last_tap_d   = last_tap_q;
        col_d        = col_q;
        is_conv_d    = is_conv_q;
        row_ptr_d    = row_ptr_q;
        stride_d     = stride_q;
        rd_d         = 1'b0;
        f_addr_d     = f_addr_q;
        w_addr_d     = w_addr_q;
        layer_d      = layer_q;
        err_d        = 1'b0;

        // RAM data lands one cycle after the read; register it as operands.
        rd_valid_d   = rd_q;
        mac_enable_d = rd_valid_q;
        mac_a_d      = mac_a_q;
        mac_b_d      = mac_b_q;
        if (rd_valid_q) begin
            mac_a_d = $signed(f_data);
            mac_b_d = $signed(w_data);
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    if (layer_legal) begin
                        state_d    = ST_FETCH;
                        rd_d       = 1'b1;
                        tap_d      = 8'd0;
                        col_d      = 3'd0;
                        is_conv_d  = (layer != 3'd2);
                        last_tap_d = (layer == 3'd2) ? 8'(FC_TAPS - 1) : 8'(CONV_TAPS - 1);
                        row_ptr_d  = f_base;
                        stride_d   = row_stride;
                        f_addr_d   = f_base;
                        w_addr_d   = w_base;
                        layer_d    = layer;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_FETCH: begin
                if (last_tap) begin
                    state_d = ST_GAP;
                end else begin
                    rd_d     = 1'b1;
                    tap_d    = tap_q + 8'd1;
                    w_addr_d = w_addr_q + WADDR_W'(1);
                    if (col_wrap) begin
                        col_d     = 3'd0;
                        row_ptr_d = next_row_ptr;
                        f_addr_d  = next_row_ptr;
                    end else begin
                        col_d    = col_q + 3'd1;
                        f_addr_d = f_addr_q + FADDR_W'(1);
                    end
                end
            end

            ST_GAP: begin
                // Leave once the pipe has drained and one idle capture cycle has passed.
                if (!rd_valid_q && !mac_enable_q) begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_FETCH) || (state_d == ST_GAP);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers; reset clears every output at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tap_q        <= '0;
            last_tap_q   <= '0;
            col_q        <= '0;
            is_conv_q    <= 1'b0;
            row_ptr_q    <= '0;
            stride_q     <= '0;
            rd_q         <= 1'b0;
            f_addr_q     <= '0;
            w_addr_q     <= '0;
            rd_valid_q   <= 1'b0;
            mac_enable_q <= 1'b0;
            mac_a_q      <= '0;
            mac_b_q      <= '0;
            layer_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            last_tap_q   <= last_tap_d;
            col_q        <= col_d;
            is_conv_q    <= is_conv_d;
            row_ptr_q    <= row_ptr_d;
            stride_q     <= stride_d;
            rd_q         <= rd_d;
            f_addr_q     <= f_addr_d;
            w_addr_q     <= w_addr_d;
            rd_valid_q   <= rd_valid_d;
            mac_enable_q <= mac_enable_d;
            mac_a_q      <= mac_a_d;
            mac_b_q      <= mac_b_d;
            layer_q      <= layer_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign f_rd       = rd_q;
    assign w_rd       = rd_q;
    assign f_addr     = f_addr_q;
    assign w_addr     = w_addr_q;
    assign mac_enable = mac_enable_q;
    assign mac_a      = mac_a_q;
    assign mac_b      = mac_b_q;
    assign mac_layer  = layer_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed testbench for mac_operand_feeder with behavioural RAMs and a MAC model.
module tb_mac_operand_feeder;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [2:0]         layer;
    logic [9:0]         f_base;
    logic [9:0]         row_stride;
    logic [13:0]        w_base;
    logic               f_rd;
    logic [9:0]         f_addr;
    logic [15:0]        f_data = 16'd0;
    logic               w_rd;
    logic [13:0]        w_addr;
    logic [15:0]        w_data = 16'd0;
    logic               mac_enable;
    logic signed [15:0] mac_a;
    logic signed [15:0] mac_b;
    logic [2:0]         mac_layer;
    logic               busy;
    logic               done;
    logic               err;

    // RAM contents: constant feature value, weight either constant or its own address.
    logic [15:0]        f_val;
    logic [15:0]        w_val;
    logic               w_use_addr;

    // MAC model state.
    logic signed [31:0] acc;
    logic signed [31:0] prod;
    logic               prev_en;

    int checks = 0;
    int errors = 0;

    mac_operand_feeder #(.FADDR_W(10), .WADDR_W(14)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .layer      (layer),
        .f_base     (f_base),
        .row_stride (row_stride),
        .w_base     (w_base),
        .f_rd       (f_rd),
        .f_addr     (f_addr),
        .f_data     (f_data),
        .w_rd       (w_rd),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .mac_enable (mac_enable),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_layer  (mac_layer),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAMs: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (f_rd) f_data <= f_val;
        if (w_rd) w_data <= w_use_addr ? 16'(w_addr) : w_val;
    end

    // Accumulator: sums products while enabled, restarts on the first enable after a gap.
    assign prod = mac_a * mac_b;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= 32'sd0;
            prev_en <= 1'b0;
        end else begin
            prev_en <= mac_enable;
            if (mac_enable) acc <= (prev_en ? acc : 32'sd0) + prod;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic checkFlag(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkFlag({tag, " f_rd"}, f_rd, 1'b0);
        checkFlag({tag, " w_rd"}, w_rd, 1'b0);
        checkOutput({tag, " f_addr"}, 32'(f_addr), 32'd0);
        checkOutput({tag, " w_addr"}, 32'(w_addr), 32'd0);
        checkFlag({tag, " mac_enable"}, mac_enable, 1'b0);
        checkOutput({tag, " mac_a"}, 32'(mac_a), 32'd0);
        checkOutput({tag, " mac_b"}, 32'(mac_b), 32'd0);
        checkOutput({tag, " mac_layer"}, 32'(mac_layer), 32'd0);
        checkFlag({tag, " busy"}, busy, 1'b0);
        checkFlag({tag, " done"}, done, 1'b0);
        checkFlag({tag, " err"}, err, 1'b0);
    endtask

    // Drives a start request; called at a negedge, sampled at the next posedge (cycle 0).
    task automatic applyStimulus(input logic [2:0] lay, input logic [9:0] fb,
                                 input logic [9:0] st, input logic [13:0] wb);
        layer      = lay;
        f_base     = fb;
        row_stride = st;
        w_base     = wb;
        start      = 1'b1;
    endtask

    // Follows one run cycle by cycle up to and including the done cycle.
    task automatic runCheck(input string tag, input int n, input bit conv,
                            input logic [9:0] fb, input logic [9:0] st, input logic [13:0] wb,
                            input logic [2:0] lay, input logic signed [31:0] exp_sum,
                            input bit mid_start);
        int k;
        int fa;
        int wa;
        for (int j = 1; j <= n + 4; j++) begin
            @(negedge clk);
            if (j == 1) start = 1'b0;
            if (mid_start && j == 10) begin
                start  = 1'b1;
                layer  = 3'd2;
                f_base = 10'd500;
                w_base = 14'd99;
            end
            if (mid_start && j == 11) start = 1'b0;
            checkFlag($sformatf("%s f_rd c%0d", tag, j), f_rd, j <= n);
            checkFlag($sformatf("%s w_rd c%0d", tag, j), w_rd, j <= n);
            if (j <= n) begin
                k  = j - 1;
                fa = conv ? (int'(fb) + (k / 5) * int'(st) + (k % 5)) : (int'(fb) + k);
                wa = int'(wb) + k;
                checkOutput($sformatf("%s f_addr k%0d", tag, k), 32'(f_addr), 32'(fa[9:0]));
                checkOutput($sformatf("%s w_addr k%0d", tag, k), 32'(w_addr), 32'(wa[13:0]));
            end
            checkFlag($sformatf("%s mac_enable c%0d", tag, j), mac_enable, (j >= 3) && (j <= n + 2));
            checkFlag($sformatf("%s busy c%0d", tag, j), busy, j <= n + 3);
            checkFlag($sformatf("%s done c%0d", tag, j), done, j == n + 4);
            checkFlag($sformatf("%s err c%0d", tag, j), err, 1'b0);
            if (j == 1 || j == n + 4)
                checkOutput($sformatf("%s mac_layer c%0d", tag, j), 32'(mac_layer), 32'(lay));
            if (j == n + 4)
                checkOutput($sformatf("%s mac out", tag), acc, exp_sum);
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        layer      = 3'd0;
        f_base     = 10'd0;
        row_stride = 10'd0;
        w_base     = 14'd0;
        f_val      = 16'd1;
        w_val      = 16'd0;
        w_use_addr = 1'b1;

        // Power-on reset, then idle with no reads.
        @(negedge clk);
        checkAllZero("por");
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checkFlag($sformatf("idle f_rd c%0d", j), f_rd, 1'b0);
            checkFlag($sformatf("idle busy c%0d", j), busy, 1'b0);
        end

        // Conv window, w_data = address: sum 0..24 = 300.
        $display("[TB] conv layer 0");
        applyStimulus(3'd0, 10'd0, 10'd28, 14'd0);
        runCheck("conv0", 25, 1'b1, 10'd0, 10'd28, 14'd0, 3'd0, 32'sd300, 1'b0);

        // Illegal layer: err only in cycle 1, nothing else moves.
        $display("[TB] illegal layer");
        @(negedge clk);
        applyStimulus(3'd5, 10'd0, 10'd28, 14'd0);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            if (j == 1) start = 1'b0;
            checkFlag($sformatf("illegal err c%0d", j), err, j == 1);
            checkFlag($sformatf("illegal busy c%0d", j), busy, 1'b0);
            checkFlag($sformatf("illegal f_rd c%0d", j), f_rd, 1'b0);
            checkFlag($sformatf("illegal mac_enable c%0d", j), mac_enable, 1'b0);
        end

        // FC row with feature address wrap: 192 * (2 * -3) = -1152.
        $display("[TB] fc layer 2");
        f_val      = 16'd2;
        w_val      = 16'hFFFD;
        w_use_addr = 1'b0;
        applyStimulus(3'd2, 10'd1000, 10'd0, 14'd200);
        runCheck("fc", 192, 1'b0, 10'd1000, 10'd0, 14'd200, 3'd2, -32'sd1152, 1'b0);

        // Conv with a start while busy, then a second conv started in the done cycle.
        $display("[TB] ignored start and back-to-back");
        @(negedge clk);
        f_val      = 16'd1;
        w_use_addr = 1'b1;
        applyStimulus(3'd0, 10'd0, 10'd28, 14'd0);
        runCheck("conv_mid", 25, 1'b1, 10'd0, 10'd28, 14'd0, 3'd0, 32'sd300, 1'b1);
        applyStimulus(3'd1, 10'd0, 10'd28, 14'd1);
        runCheck("conv_b2b", 25, 1'b1, 10'd0, 10'd28, 14'd1, 3'd1, 32'sd325, 1'b0);

        // Reset in cycle 10 of an FC run.
        $display("[TB] reset during fc");
        @(negedge clk);
        f_val      = 16'd2;
        w_val      = 16'hFFFD;
        w_use_addr = 1'b0;
        applyStimulus(3'd2, 10'd1000, 10'd0, 14'd200);
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (j == 1) start = 1'b0;
        end
        checkFlag("pre-reset f_rd", f_rd, 1'b1);
        #2 reset = 1'b1;
        #1 checkAllZero("midrun reset");
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            checkFlag($sformatf("post-reset f_rd c%0d", j), f_rd, 1'b0);
            checkFlag($sformatf("post-reset mac_enable c%0d", j), mac_enable, 1'b0);
            checkFlag($sformatf("post-reset done c%0d", j), done, 1'b0);
            checkFlag($sformatf("post-reset busy c%0d", j), busy, 1'b0);
        end

        // Fresh conv run after the reset.
        f_val      = 16'd1;
        w_use_addr = 1'b1;
        applyStimulus(3'd0, 10'd0, 10'd28, 14'd0);
        runCheck("conv_after_reset", 25, 1'b1, 10'd0, 10'd28, 14'd0, 3'd0, 32'sd300, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
